multi_result_queue: RTL

- Parametrised successor to the single-channel result queue.
- Accepts results from NCH independent producer channels, each into its own FIFO.
- Merges all channels onto one valid/ready read port using round-robin arbitration, and tags each word with its source channel.
- Adds per-channel occupancy, almost-full, and sticky overflow status, which the single-channel queue lacks.

---
 rtl/multi_result_queue_pkg.sv | 59 +++++
 rtl/multi_result_queue_channel_fifo.sv | 67 ++++++
 rtl/multi_result_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/multi_result_queue_pkg.sv
// Shared constants, derived-width helpers, typedefs and the round-robin search
// used by the multi-channel result queue.
package pkg_multi_result_queue;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_NCH       = 4;
    localparam int DEF_AF_THRESH = DEF_DEPTH - 2;

    // Upper bound on channels the arbiter search can handle.
    localparam int MAX_NCH = 64;
    localparam int IDXW    = 6;

    function automatic int calc_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_pw(input int d);
        return $clog2(d);
    endfunction

    function automatic int calc_cntw(input int d);
        return $clog2(d) + 1;
    endfunction

    localparam int CW   = calc_cw(DEF_NCH);
    localparam int PW   = calc_pw(DEF_DEPTH);
    localparam int CNTW = calc_cntw(DEF_DEPTH);

    typedef logic [DEF_WIDTH-1:0] t_data;
    typedef logic [CW-1:0]        t_chan;
    typedef logic [CNTW-1:0]      t_cnt;

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] idx;
    } t_grant;

    // First set bit of req at or above ptr, wrapping at n.
    function automatic t_grant rr_search(input logic [MAX_NCH-1:0] req,
                                         input int unsigned        ptr,
                                         input int unsigned        n);
        t_grant      g;
        int unsigned idx;
        g = '0;
        for (int unsigned k = 0; k < MAX_NCH; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!g.found && req[idx[IDXW-1:0]]) begin
                    g.found = 1'b1;
                    g.idx   = idx[IDXW-1:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/multi_result_queue_channel_fifo.sv
// Single producer channel FIFO: wrap-bit pointers, occupancy, almost-full and
// sticky overflow status.
module rq_channel_fifo
    import pkg_multi_result_queue::*;
#(
    parameter int  WIDTH     = DEF_WIDTH,
    parameter int  DEPTH     = DEF_DEPTH,
    parameter int  AF_THRESH = DEF_AF_THRESH,
    localparam int PW        = calc_pw(DEPTH),
    localparam int CNTW      = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [CNTW-1:0]  count,
    output logic             overflow
);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             accept;
    logic             drop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (count >= CNTW'(AF_THRESH));
    assign overflow    = overflow_q;
    assign head        = mem_q[rd_ptr_q[PW-1:0]];

    // A pop in the same cycle frees the slot, so a full channel can still accept.
    always_comb begin
        accept     = wr_en && (!full || pop);
        drop       = wr_en && !accept;
        wr_ptr_d   = wr_ptr_q + (PW+1)'(accept);
        rd_ptr_d   = rd_ptr_q + (PW+1)'(pop);
        overflow_d = (overflow_q && !ovf_clr) || drop;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; emptiness comes from the pointers, so stale data is never read.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/multi_result_queue.sv
// NCH channel FIFOs merged onto one valid/ready port by a round-robin arbiter,
// with each output word tagged by its source channel.
module multi_result_queue
    import pkg_multi_result_queue::*;
#(
    parameter int  WIDTH     = DEF_WIDTH,
    parameter int  DEPTH     = DEF_DEPTH,
    parameter int  NCH       = DEF_NCH,
    parameter int  AF_THRESH = DEPTH - 2,
    localparam int CW        = calc_cw(NCH),
    localparam int CNTW      = calc_cntw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        wr_en,
    input  logic [NCH*WIDTH-1:0]  wr_data,
    output logic [NCH-1:0]        full,
    output logic [NCH-1:0]        almost_full,
    output logic [NCH*CNTW-1:0]   count,
    output logic [NCH-1:0]        overflow,
    input  logic [NCH-1:0]        ovf_clr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic [CW-1:0]         rd_chan
);

    logic [NCH-1:0]     empty;
    logic [NCH-1:0]     pop;
    logic [WIDTH-1:0]   head [NCH];
    logic [MAX_NCH-1:0] req_ext;
    t_grant             grant;
    logic [CW-1:0]      grant_chan;
    logic               load;

    logic               rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [CW-1:0]      rd_chan_q, rd_chan_d;
    logic [CW-1:0]      rr_ptr_q, rr_ptr_d;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        rq_channel_fifo #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (wr_en[c]),
            .wr_data     (wr_data[c*WIDTH +: WIDTH]),
            .pop         (pop[c]),
            .ovf_clr     (ovf_clr[c]),
            .head        (head[c]),
            .empty       (empty[c]),
            .full        (full[c]),
            .almost_full (almost_full[c]),
            .count       (count[c*CNTW +: CNTW]),
            .overflow    (overflow[c])
        );
    end

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        req_ext          = '0;
        req_ext[NCH-1:0] = ~empty;
        load             = !rd_valid_q || rd_ready;
        grant            = rr_search(req_ext, 32'(rr_ptr_q), NCH);
        grant_chan       = CW'(grant.idx);

        pop        = '0;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_chan_d  = rd_chan_q;
        rr_ptr_d   = rr_ptr_q;

        if (load) begin
            rd_valid_d = grant.found;
            if (grant.found) begin
                pop[grant_chan] = 1'b1;
                rd_data_d       = head[grant_chan];
                rd_chan_d       = grant_chan;
                rr_ptr_d        = (grant_chan == CW'(NCH - 1)) ? '0 : grant_chan + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_chan_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_chan_q  <= rd_chan_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_chan  = rd_chan_q;

endmodule
